// File: rtl/karatsuba_pkg.sv
// Shared types and elaboration helpers for the Karatsuba multiplier.
package karatsuba_pkg;

  typedef enum logic [1:0] {IDLE, MUL, COMBINE, OUT} state_t;

  localparam int MIN_WIDTH = 4;

  function automatic int latency(input int width);
    return width / 2 + 3;
  endfunction

  function automatic bit width_ok(input int width);
    return ((width % 2) == 0) && (width >= MIN_WIDTH);
  endfunction

endpackage

// File: rtl/shift_add_mult.sv
// Unsigned W x W shift-add multiplier, one partial product per cycle.
module shift_add_mult #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] product,
  output logic           done
);

  localparam int CW = $clog2(W + 1);

  logic [2*W-1:0] mcand;
  logic [W-1:0]   mplier;
  logic [2*W-1:0] acc;
  logic [CW-1:0]  cnt;

  // start has priority over a running iteration so the unit can be restarted
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      done   <= 1'b0;
    end else if (start) begin
      mcand  <= (2*W)'(a);
      mplier <= b;
      acc    <= '0;
      cnt    <= CW'(W);
      done   <= 1'b0;
    end else if (cnt != '0) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
      done   <= (cnt == CW'(1));
    end else begin
      done   <= 1'b0;
    end
  end

  assign product = acc;

endmodule

// File: rtl/karatsuba_mult_pipe.sv
// Sequential Karatsuba multiplier: three parallel shift-add units on operand
// halves, signed handled as sign-magnitude around an unsigned core.
module karatsuba_mult_pipe
  import karatsuba_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int H  = WIDTH / 2;
  localparam int SW = H + 1;

  if (!width_ok(WIDTH)) begin : g_width_check
    $error("karatsuba_mult_pipe: WIDTH must be even and >= 4");
  end

  state_t state, state_nxt;
  logic              neg;
  logic              start;
  logic [WIDTH-1:0]  a_abs, b_abs;
  logic [SW-1:0]     a_sum, b_sum;
  logic [2*H-1:0]    z0, z2;
  logic [2*SW-1:0]   z1_raw, z1;
  logic [2:0]        done, sticky;
  logic              all_done;
  logic [2*WIDTH-1:0] mag;

  always_comb begin
    a_abs = (signed_mode && a[WIDTH-1]) ? -a : a;
    b_abs = (signed_mode && b[WIDTH-1]) ? -b : b;
    a_sum = {1'b0, a_abs[H-1:0]} + {1'b0, a_abs[WIDTH-1:H]};
    b_sum = {1'b0, b_abs[H-1:0]} + {1'b0, b_abs[WIDTH-1:H]};
  end

  assign start = (state == IDLE) && in_valid;

  shift_add_mult #(.W(H)) u_z0 (
    .clk(clk), .rst(rst), .start(start),
    .a(a_abs[H-1:0]), .b(b_abs[H-1:0]), .product(z0), .done(done[0])
  );

  shift_add_mult #(.W(H)) u_z2 (
    .clk(clk), .rst(rst), .start(start),
    .a(a_abs[WIDTH-1:H]), .b(b_abs[WIDTH-1:H]), .product(z2), .done(done[2])
  );

  shift_add_mult #(.W(SW)) u_z1 (
    .clk(clk), .rst(rst), .start(start),
    .a(a_sum), .b(b_sum), .product(z1_raw), .done(done[1])
  );

  // done is a single-cycle pulse; the H-bit units finish one cycle early
  always_ff @(posedge clk) begin
    if (rst || start) sticky <= '0;
    else              sticky <= sticky | done;
  end

  assign all_done = &(sticky | done);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = MUL;
      MUL:     if (all_done) state_nxt = COMBINE;
      COMBINE: state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == OUT);
    busy      = (state != IDLE);
  end

  always_comb begin
    z1  = z1_raw - (2*SW)'(z2) - (2*SW)'(z0);
    mag = ((2*WIDTH)'(z2) << WIDTH) + ((2*WIDTH)'(z1) << H) + (2*WIDTH)'(z0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      neg     <= 1'b0;
      product <= '0;
    end else begin
      if (start) neg <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
      if (state == COMBINE) product <= neg ? -mag : mag;
    end
  end

endmodule

// File: tb/tb_karatsuba_mult_pipe.sv
// Directed and randomised checks of karatsuba_mult_pipe at WIDTH=16 and 32.
module tb_karatsuba_mult_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        iv16, ir16, sm16, ov16, or16, busy16;
  logic [15:0] a16, b16;
  logic [31:0] p16;
  logic        iv32, ir32, sm32, ov32, or32, busy32;
  logic [31:0] a32, b32;
  logic [63:0] p32;

  karatsuba_mult_pipe #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .signed_mode(sm16), .out_valid(ov16), .out_ready(or16), .product(p16), .busy(busy16)
  );

  karatsuba_mult_pipe #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
    .signed_mode(sm32), .out_valid(ov32), .out_ready(or32), .product(p32), .busy(busy32)
  );

  int tests = 0;
  int failed = 0;

  typedef struct {
    bit          w32;
    logic [31:0] a;
    logic [31:0] b;
    bit          sm;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input bit w32, input logic [31:0] av,
                                          input logic [31:0] bv, input bit sm);
    longint sa, sb, r;
    logic [15:0] a1, b1;
    a1 = av[15:0];
    b1 = bv[15:0];
    if (w32) begin
      sa = sm ? longint'($signed(av)) : longint'(av);
      sb = sm ? longint'($signed(bv)) : longint'(bv);
    end else begin
      sa = sm ? longint'($signed(a1)) : longint'(a1);
      sb = sm ? longint'($signed(b1)) : longint'(b1);
    end
    r = sa * sb;
    return w32 ? r : {32'b0, r[31:0]};
  endfunction

  // Issue one operation; returns at the negedge where out_valid is first seen.
  task automatic do_op(input bit w32, input logic [31:0] av, input logic [31:0] bv,
                       input bit sm, input logic [63:0] exp, input string nm);
    int cyc;
    bit rdy_bad;
    @(negedge clk);
    check({nm, " in_ready before"}, 64'(w32 ? ir32 : ir16), 64'd1);
    if (w32) begin a32 = av; b32 = bv; sm32 = sm; iv32 = 1'b1; end
    else begin a16 = av[15:0]; b16 = bv[15:0]; sm16 = sm; iv16 = 1'b1; end
    @(posedge clk);
    @(negedge clk);
    iv16 = 1'b0; iv32 = 1'b0;
    a16 = ~av[15:0]; b16 = ~bv[15:0]; sm16 = ~sm;
    a32 = ~av; b32 = ~bv; sm32 = ~sm;
    cyc = 0;
    rdy_bad = 1'b0;
    while (!(w32 ? ov32 : ov16) && cyc < 200) begin
      if (w32 ? ir32 : ir16) rdy_bad = 1'b1;
      @(negedge clk);
      cyc++;
    end
    check({nm, " latency"}, 64'(cyc), w32 ? 64'd19 : 64'd11);
    check({nm, " product"}, w32 ? p32 : {32'b0, p16}, exp);
    check({nm, " in_ready low while busy"}, 64'(rdy_bad), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    iv16 = 1'b0; iv32 = 1'b0; or16 = 1'b1; or32 = 1'b1;
    a16 = '0; b16 = '0; sm16 = 1'b0; a32 = '0; b32 = '0; sm32 = 1'b0;

    vecs.push_back('{0, 32'h1234, 32'h5678, 0, 64'h06260060});
    vecs.push_back('{0, 32'hFFFF, 32'hFFFF, 0, 64'hFFFE0001});
    vecs.push_back('{0, 32'hFFFF, 32'hFFFF, 1, 64'h00000001});
    vecs.push_back('{0, 32'h8000, 32'h8000, 1, 64'h40000000});
    vecs.push_back('{0, 32'h8000, 32'h0001, 1, 64'hFFFF8000});
    vecs.push_back('{0, 32'h8000, 32'h8000, 0, 64'h40000000});
    vecs.push_back('{0, 32'h7FFF, 32'h8000, 1, 64'hC0008000});
    vecs.push_back('{0, 32'h0002, 32'hFFFD, 1, 64'hFFFFFFFA});
    vecs.push_back('{0, 32'h0000, 32'hFFFF, 0, 64'h00000000});
    vecs.push_back('{1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 64'hFFFFFFFE00000001});
    vecs.push_back('{1, 32'h80000000, 32'h80000000, 1, 64'h4000000000000000});
    vecs.push_back('{1, 32'h00012345, 32'hFFFFFFFF, 1, 64'hFFFFFFFFFFFEDCBB});

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset in_ready", 64'(ir16), 64'd1);
    check("reset out_valid", 64'(ov16), 64'd0);
    check("reset product", {32'b0, p16}, 64'd0);
    check("reset busy", 64'(busy16), 64'd0);

    // reset beats a simultaneous in_valid
    iv16 = 1'b1; a16 = 16'd7; b16 = 16'd9;
    @(posedge clk);
    @(negedge clk);
    check("rst+in_valid busy", 64'(busy16), 64'd0);
    iv16 = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++)
      do_op(vecs[i].w32, vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].exp, $sformatf("vec%0d", i));

    // backpressure: product and handshake frozen while out_ready is low
    begin
      bit hold_bad;
      hold_bad = 1'b0;
      @(negedge clk);
      or16 = 1'b0;
      do_op(0, 32'h00FF, 32'h0101, 0, 64'h0000FFFF, "bp");
      for (int i = 0; i < 20; i++) begin
        a16 = 16'(i * 16'h1357); b16 = ~a16; iv16 = i[0];
        @(negedge clk);
        if (p16 !== 32'h0000FFFF || ir16 !== 1'b0 || ov16 !== 1'b1) hold_bad = 1'b1;
      end
      check("bp held", 64'(hold_bad), 64'd0);
      iv16 = 1'b0; or16 = 1'b1;
      @(negedge clk);
      check("bp release in_ready", 64'(ir16), 64'd1);
      check("bp release out_valid", 64'(ov16), 64'd0);
      do_op(0, 32'h0100, 32'h0100, 0, 64'h00010000, "bp next");
    end

    // reset four cycles into MUL
    @(negedge clk);
    a16 = 16'h1234; b16 = 16'h5678; sm16 = 1'b0; iv16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv16 = 1'b0;
    repeat (3) @(negedge clk);
    check("mid busy", 64'(busy16), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid rst out_valid", 64'(ov16), 64'd0);
    check("mid rst product", {32'b0, p16}, 64'd0);
    check("mid rst in_ready", 64'(ir16), 64'd1);
    do_op(0, 32'd3, 32'd5, 0, 64'd15, "after rst");

    for (int i = 0; i < 60; i++) begin
      bit w, s;
      logic [31:0] av, bv;
      w = (i >= 30);
      s = 1'($urandom_range(0, 1));
      for (int k = 0; k < 2; k++) begin
        logic [31:0] v;
        case ($urandom_range(0, 5))
          0: v = 32'h0;
          1: v = 32'hFFFFFFFF;
          2: v = 32'h80000000;
          3: v = 32'h1;
          default: v = $urandom;
        endcase
        if (!w) v = (v == 32'h80000000) ? 32'h8000 : {16'b0, v[15:0]};
        if (k == 0) av = v; else bv = v;
      end
      do_op(w, av, bv, s, ref_mul(w, av, bv, s), $sformatf("rnd%0d", i));
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/karatsuba_mult_pipe.md
Name: karatsuba_mult_pipe

Overview:
- Parametrised sequential Karatsuba multiplier with a valid/ready handshake on both sides and a per-operation signed/unsigned mode.
- Splits each WIDTH-bit operand into halves and runs the three partial products on three parallel shift-add sub-multipliers, not sequentially.
- Combines the partial products arithmetically and holds the result until it is accepted.
- Sits in the arithmetic datapath between the operand staging logic and the accumulator/writeback stage.

Parameters:
WIDTH, 16, operand width; must be even and >= 4
H, WIDTH/2, half width (derived, not overridden)
SW, H+1, width of the half-sum operands (derived)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
in_valid  in  1  operands and mode valid
in_ready  out  1  block can accept an operation
a  in  WIDTH  multiplicand
b  in  WIDTH  multiplier
signed_mode  in  1  1 = two's-complement operands, 0 = unsigned
out_valid  out  1  product valid
out_ready  in  1  consumer accepts the product
product  out  2*WIDTH  result of a*b, exact
busy  out  1  operation in flight (any state other than IDLE)

Behaviour:
- Single clock domain: clk. Reset rst is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values: state=IDLE, in_ready=1, out_valid=0, product=0, busy=0. Sub-multipliers are cleared.
- States: IDLE, MUL, COMBINE, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid, latch a, b and signed_mode, pulse start to all three sub-multipliers, go to MUL.
  - Signed mode: latch |a| and |b| as WIDTH-bit unsigned values and neg = a[MSB]^b[MSB]; |-2^(WIDTH-1)| = 2^(WIDTH-1).
  - Unsigned mode: neg=0.
- MUL:
  - z0 = aL*bL and z2 = aH*bH on H-bit units; z1_raw = (aL+aH)*(bL+bH) on an SW-bit unit.
  - Each unit's done flag is captured in a sticky bit; leave MUL only when all three sticky bits are set.
- COMBINE:
  - z1 = z1_raw - z2 - z0, computed in 2*SW bits. The result is non-negative by construction.
  - mag = (z2<<WIDTH) + (z1<<H) + z0, using additions (no OR), in 2*WIDTH bits.
  - product <= neg ? -mag : mag, then go to OUT.
- OUT:
  - out_valid=1; product is held stable.
  - On out_ready, go to IDLE with out_valid=0 on the next cycle.
- Latency: out_valid rises exactly SW+2 = H+3 cycles after the acceptance edge, giving 11 cycles at WIDTH=16.
- Throughput: one operation in flight. in_ready=0 in MUL, COMBINE and OUT. A new operation cannot be accepted in the same cycle as the out handshake; acceptance happens on the next IDLE cycle.
- Backpressure: with out_ready held low, the block remains in OUT indefinitely. product and out_valid stay constant, and in_valid is ignored.
- Input stability: changes on a, b or signed_mode after acceptance have no effect.
- Reset mid-operation: reset in any state returns to the reset values on the next edge. A partially computed result is never presented.
- Simultaneous rst and in_valid: reset wins and the operation is not accepted.
- Zero operands: these go through the full latency. There is no early-out.

Decomposition:
- Package karatsuba_pkg holds:
  - the state enum (IDLE, MUL, COMBINE, OUT);
  - a function giving the latency for a given WIDTH (WIDTH/2+3);
  - a width-check constant used by an elaboration-time assertion that WIDTH is even.
- Sub-module shift_add_mult, parameter W:
  - Ports: clk, rst (sync), start, a[W], b[W], product[2W], done.
  - Takes W iterations; done is a one-cycle pulse after the last iteration.
  - A start while running restarts the unit.
- The top level instantiates it three times: twice with W=H and once with W=SW.

Test Plan:
1. Unsigned, WIDTH=16, a=0x1234, b=0x5678, out_ready=1 -> product=0x06260060; out_valid rises 11 cycles after acceptance; in_ready=0 during that time.
2. Unsigned a=0xFFFF, b=0xFFFF (half-sum carries) -> product=0xFFFE0001.
3. Signed mode: a=0xFFFF, b=0xFFFF gives 0x00000001. a=0x8000, b=0x8000 gives 0x40000000. a=0x8000, b=0x0001 gives 0xFFFF8000.
4. Backpressure: hold out_ready=0 for 20 cycles after out_valid, and toggle a/b/in_valid -> product stays constant and in_ready stays 0. Then raise out_ready for one cycle -> IDLE, and the next operation is accepted.
5. Reset mid-operation: assert rst 4 cycles into MUL -> next edge gives out_valid=0, product=0, in_ready=1. A following 3*5 operation returns 15 with full latency.
6. Randomised sweep at WIDTH=16 and WIDTH=32 (both modes, including 0, max and most-negative values) -> product matches the reference a*b; latency is always WIDTH/2+3.
